// File: rtl/sm3_feed_pkg.sv
// sm3_feed_pkg: shared state type, byte-mask constants and helpers for the SM3 message feeder
package sm3_feed_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_t;
    localparam logic [3:0] MASK_FULL = 4'hF;
    localparam logic [3:0] MASK_B1 = 4'b1000;
    localparam logic [3:0] MASK_B2 = 4'b1100;
    localparam logic [3:0] MASK_B3 = 4'b1110;
    localparam int ENTRY_W = 37;
    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return {2'b0, m[0]} + {2'b0, m[1]} + {2'b0, m[2]} + {2'b0, m[3]};
    endfunction
    function automatic logic legal_last(input logic [3:0] m);
        return m == MASK_B1 || m == MASK_B2 || m == MASK_B3 || m == MASK_FULL;
    endfunction
endpackage

// File: rtl/sm3_feed_fifo.sv
// sm3_feed_fifo: synchronous FIFO with wrap-bit pointers and registered full/empty flags
module sm3_feed_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp, wp_n, rp_n;
    logic do_push, do_pop;
    always_comb begin
        do_push = push & !full;
        do_pop = pop & !empty;
        wp_n = do_push ? wp + ONE : wp;
        rp_n = do_pop ? rp + ONE : rp;
        dout = mem[rp[AW-1:0]];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp <= wp_n;
            rp <= rp_n;
            full <= (wp_n ^ rp_n) == {1'b1, {AW{1'b0}}};
            empty <= wp_n == rp_n;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sm3_msg_feeder.sv
// sm3_msg_feeder: buffers message words into the SM3 core port and holds the returned digest
module sm3_msg_feeder import sm3_feed_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [31:0]      wr_d,
    input  logic [3:0]       wr_byte,
    input  logic             wr_lst,
    output logic [31:0]      msg_inpt_d,
    output logic [3:0]       msg_inpt_vld_byte,
    output logic             msg_inpt_vld,
    output logic             msg_inpt_lst,
    input  logic             msg_inpt_rdy,
    input  logic [255:0]     cmprss_otpt_res,
    input  logic             cmprss_otpt_vld,
    input  logic [2:0]       dgst_rd_idx,
    output logic [31:0]      dgst_rd_d,
    output logic             dgst_vld,
    input  logic             dgst_clr,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] byte_cnt
);
    state_t state;
    logic live, lst_seen, full, empty, wr_acc, xfer;
    logic [3:0] wr_mask;
    logic [ENTRY_W-1:0] head;
    logic [255:0] dgst;
    logic [CNT_W:0] cnt_sum;
    sm3_feed_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_acc), .pop(xfer),
        .din({wr_d, wr_mask, wr_lst}), .dout(head), .full(full), .empty(empty)
    );
    // live keeps wr_rdy low while in reset and for the first cycle after release
    always_comb begin
        wr_rdy = live & !full & !lst_seen & (state == S_IDLE || state == S_FEED);
        wr_acc = wr_vld & wr_rdy;
        wr_mask = (wr_lst && legal_last(wr_byte)) ? wr_byte : MASK_FULL;
        msg_inpt_vld = state == S_FEED && !empty;
        xfer = msg_inpt_vld & msg_inpt_rdy;
        {msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst} = msg_inpt_vld ? head : '0;
        cnt_sum = {1'b0, byte_cnt} + {{(CNT_W-2){1'b0}}, popcount4(msg_inpt_vld_byte)};
        busy = state != S_IDLE;
        dgst_rd_d = dgst_vld ? dgst[{~dgst_rd_idx, 5'd0} +: 32] : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            live <= 1'b0;
            lst_seen <= 1'b0;
            err <= 1'b0;
            dgst_vld <= 1'b0;
            dgst <= '0;
            byte_cnt <= '0;
        end else begin
            live <= 1'b1;
            if (wr_acc && wr_lst) lst_seen <= 1'b1;
            if (wr_acc && wr_lst && !legal_last(wr_byte)) err <= 1'b1;
            if (state == S_IDLE && wr_acc) byte_cnt <= '0;
            else if (xfer) byte_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            case (state)
                S_IDLE: if (wr_acc) state <= S_FEED;
                S_FEED: if (xfer && msg_inpt_lst) state <= S_WAIT;
                S_WAIT: if (cmprss_otpt_vld) begin
                    state <= S_DONE;
                    dgst <= cmprss_otpt_res;
                    dgst_vld <= 1'b1;
                end
                S_DONE: if (dgst_clr) begin
                    state <= S_IDLE;
                    dgst_vld <= 1'b0;
                    err <= 1'b0;
                    lst_seen <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm3_msg_feeder.sv
// tb_sm3_msg_feeder: table-driven and scoreboard-checked bench for the SM3 message feeder
module tb_sm3_msg_feeder;
    logic clk = 0, rst_n = 0, wr_vld = 0, wr_lst = 0, msg_inpt_rdy = 0;
    logic cmprss_otpt_vld = 0, dgst_clr = 0;
    logic wr_rdy, msg_inpt_vld, msg_inpt_lst, dgst_vld, busy, err;
    logic [31:0] wr_d = 0, msg_inpt_d, dgst_rd_d, byte_cnt;
    logic [3:0] wr_byte = 0, msg_inpt_vld_byte, last_mask;
    logic [255:0] cmprss_otpt_res = 0;
    logic [2:0] dgst_rd_idx = 0;
    logic [36:0] sb[$];
    logic [36:0] sb_e;
    logic [31:0] abc_w [8];
    int checks = 0, failures = 0, n_lst = 0, nl_exp = 0, acc;
    localparam logic [255:0] ABC =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  b;
        logic [3:0]  m;
        logic        e;
        logic [31:0] cnt;
    } vec_t;
    vec_t tbl [7];

    sm3_msg_feeder dut (
        .clk(clk), .rst_n(rst_n), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_d(wr_d),
        .wr_byte(wr_byte), .wr_lst(wr_lst), .msg_inpt_d(msg_inpt_d),
        .msg_inpt_vld_byte(msg_inpt_vld_byte), .msg_inpt_vld(msg_inpt_vld),
        .msg_inpt_lst(msg_inpt_lst), .msg_inpt_rdy(msg_inpt_rdy),
        .cmprss_otpt_res(cmprss_otpt_res), .cmprss_otpt_vld(cmprss_otpt_vld),
        .dgst_rd_idx(dgst_rd_idx), .dgst_rd_d(dgst_rd_d), .dgst_vld(dgst_vld),
        .dgst_clr(dgst_clr), .busy(busy), .err(err), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_mask(input logic [3:0] b, input logic l);
        if (!l) return 4'hF;
        if (b == 4'b1000 || b == 4'b1100 || b == 4'b1110 || b == 4'b1111) return b;
        return 4'hF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard: push on accepted write, pop and compare on core-side transfer
    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            if (wr_vld && wr_rdy) sb.push_back({wr_d, exp_mask(wr_byte, wr_lst), wr_lst});
            if (msg_inpt_vld && msg_inpt_rdy) begin
                if (sb.size() == 0) chk("xfer_unexpected", {msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst}, 0);
                else begin
                    sb_e = sb.pop_front();
                    chk("xfer_word", {msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst}, sb_e);
                end
                last_mask = msg_inpt_vld_byte;
                if (msg_inpt_lst) n_lst++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] d, input logic [3:0] b, input logic l);
        bit ok = 0;
        wr_vld = 1; wr_d = d; wr_byte = b; wr_lst = l;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = wr_rdy;
            tick();
        end
        wr_vld = 0; wr_lst = 0;
        chk("wr_accept_timeout", 64'(ok), 1);
    endtask

    task automatic wait_lst();
        nl_exp++;
        for (int k = 0; k < 50 && n_lst < nl_exp; k++) tick();
        chk("lst_xfer_timeout", 64'(n_lst >= nl_exp), 1);
    endtask

    task automatic finish_msg(input logic [255:0] res);
        cmprss_otpt_res = res; cmprss_otpt_vld = 1;
        tick();
        cmprss_otpt_vld = 0;
        chk("dgst_vld_set", dgst_vld, 1);
        chk("busy_done", busy, 1);
    endtask

    task automatic clear();
        dgst_clr = 1;
        tick();
        dgst_clr = 0;
        chk("clr_busy", busy, 0);
        chk("clr_dgst_vld", dgst_vld, 0);
        chk("clr_rd_zero", dgst_rd_d, 0);
        chk("clr_err", err, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wr_rdy"}, wr_rdy, 0);
        chk({tag, "_vld"}, msg_inpt_vld, 0);
        chk({tag, "_d"}, {msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cnt"}, byte_cnt, 0);
        chk({tag, "_dgst"}, {dgst_vld, dgst_rd_d}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        abc_w = '{32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
                  32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};
        tbl[0] = '{32'h61626300, 4'b1110, 4'b1110, 1'b0, 3};
        tbl[1] = '{32'hAABBCCDD, 4'b1000, 4'b1000, 1'b0, 1};
        tbl[2] = '{32'h01234567, 4'b1100, 4'b1100, 1'b0, 2};
        tbl[3] = '{32'h89ABCDEF, 4'b1111, 4'b1111, 1'b0, 4};
        tbl[4] = '{32'hCAFEF00D, 4'b0101, 4'b1111, 1'b1, 4};
        tbl[5] = '{32'h00000000, 4'b0000, 4'b1111, 1'b1, 4};
        tbl[6] = '{32'h12345678, 4'b0111, 4'b1111, 1'b1, 4};

        tick(); tick();
        chk_zero_outputs("rst");
        rst_n = 1;
        tick();

        // single-word messages, one per table row
        msg_inpt_rdy = 1;
        for (int i = 0; i < 7; i++) begin
            wr_word(tbl[i].d, tbl[i].b, 1'b1);
            chk("tbl_latency_vld", msg_inpt_vld, 1);
            chk("tbl_err", err, tbl[i].e);
            wait_lst();
            chk("tbl_mask", last_mask, tbl[i].m);
            chk("tbl_byte_cnt", byte_cnt, tbl[i].cnt);
            chk("tbl_err_hold", err, tbl[i].e);
            finish_msg(ABC);
            dgst_rd_idx = 3'(i);
            #1 chk("tbl_dgst_word", dgst_rd_d, abc_w[i]);
            dgst_rd_idx = 7;
            #1 chk("tbl_dgst_word7", dgst_rd_d, abc_w[7]);
            clear();
        end

        // backpressure: head must hold steady while rdy is low
        msg_inpt_rdy = 0;
        wr_word(32'h11223344, 4'b0011, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", msg_inpt_vld, 1);
            chk("bp_word", {msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst}, {32'h11223344, 4'hF, 1'b0});
            chk("bp_cnt", byte_cnt, 0);
            tick();
        end
        msg_inpt_rdy = 1;
        tick();
        msg_inpt_rdy = 0;
        chk("bp_single_vld", msg_inpt_vld, 0);
        chk("bp_single_cnt", byte_cnt, 4);
        wr_word(32'h55667788, 4'b1100, 1'b1);
        msg_inpt_rdy = 1;
        wait_lst();
        chk("bp_total_cnt", byte_cnt, 6);
        finish_msg(ABC);
        clear();

        // FIFO full with rdy low: 4 of 6 attempts accepted
        msg_inpt_rdy = 0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            wr_vld = 1; wr_d = 32'hA0000000 + 32'(i); wr_byte = 4'hF; wr_lst = (i == 5);
            if (wr_rdy) acc++;
            tick();
        end
        wr_vld = 0; wr_lst = 0;
        chk("full_accepted", 64'(acc), 4);
        chk("full_wr_rdy", wr_rdy, 0);
        msg_inpt_rdy = 1;
        wr_word(32'hA0000004, 4'hF, 1'b0);
        wr_word(32'hA0000005, 4'hF, 1'b1);
        wait_lst();
        chk("full_cnt", byte_cnt, 24);
        finish_msg(ABC);
        clear();

        // illegal last mask: err sticky through DONE, cleared by dgst_clr
        wr_word(32'hDEADBEEF, 4'b0101, 1'b1);
        chk("ill_err", err, 1);
        wait_lst();
        chk("ill_mask", last_mask, 4'hF);
        chk("ill_cnt", byte_cnt, 4);
        finish_msg(ABC);
        chk("ill_err_done", err, 1);
        clear();

        // stray digest pulse in FEED, stray clear in WAIT_RES, write blocked after lst
        wr_word(32'h01020304, 4'hF, 1'b0);
        tick(); tick();
        cmprss_otpt_res = ABC; cmprss_otpt_vld = 1;
        tick();
        cmprss_otpt_vld = 0;
        chk("stray_res_busy", busy, 1);
        chk("stray_res_dgst", dgst_vld, 0);
        chk("stray_res_wr_rdy", wr_rdy, 1);
        msg_inpt_rdy = 0;
        wr_word(32'h05060708, 4'b1000, 1'b1);
        chk("after_lst_wr_rdy", wr_rdy, 0);
        chk("after_lst_vld", msg_inpt_vld, 1);
        msg_inpt_rdy = 1;
        wait_lst();
        chk("wait_wr_rdy", wr_rdy, 0);
        dgst_clr = 1;
        tick();
        dgst_clr = 0;
        chk("stray_clr_busy", busy, 1);
        chk("stray_clr_dgst", dgst_vld, 0);
        finish_msg(~ABC);
        dgst_rd_idx = 0;
        #1 chk("stray_dgst_word", dgst_rd_d, 32'h99380f0b);
        chk("stray_cnt", byte_cnt, 5);
        clear();

        // reset mid-FEED with 3 words still queued
        msg_inpt_rdy = 0;
        for (int i = 0; i < 4; i++) wr_word(32'hB0000000 + 32'(i), 4'hF, 1'b0);
        msg_inpt_rdy = 1;
        tick();
        msg_inpt_rdy = 0;
        chk("pre_rst_cnt", byte_cnt, 4);
        chk("pre_rst_vld", msg_inpt_vld, 1);
        #2 rst_n = 0;
        #1 chk_zero_outputs("mid_rst");
        tick(); tick();
        rst_n = 1;
        tick();
        msg_inpt_rdy = 1;
        wr_word(32'h61626300, 4'b1110, 1'b1);
        wait_lst();
        chk("post_rst_mask", last_mask, 4'b1110);
        chk("post_rst_cnt", byte_cnt, 3);
        finish_msg(ABC);
        dgst_rd_idx = 0;
        #1 chk("post_rst_idx0", dgst_rd_d, 32'h66c7f0f4);
        dgst_rd_idx = 7;
        #1 chk("post_rst_idx7", dgst_rd_d, 32'h8f4ba8e0);
        clear();

        chk("sb_drained", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
